// File: rtl/vsap_pkg.sv
// vsap_pkg: FSM state encodings, opcode/function codes and the immediate sign-extend helper
// shared by vsap_core and vsap_alu.
package vsap_pkg;
   typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_e;
   localparam logic [2:0] OP_LW = 3'd0, OP_SW = 3'd1, OP_BEQZ = 3'd2, OP_ALU = 3'd3,
                          OP_ADDI = 3'd4, OP_SUBI = 3'd5, OP_BNEZ = 3'd6, OP_ILL = 3'd7;
   localparam logic [2:0] F_ADD = 3'd0, F_SUB = 3'd1, F_AND = 3'd2, F_OR = 3'd3,
                          F_XOR = 3'd4, F_NOT = 3'd5, F_SRL = 3'd6, F_SRA = 3'd7;
   // Sign-extends the low w bits of v to 64 bits; callers size-cast to their own width.
   function automatic logic [63:0] sext(input logic [63:0] v, input int w);
      return 64'($signed(v << (64 - w)) >>> (64 - w));
   endfunction
endpackage

// File: rtl/vsap_alu.sv
// vsap_alu: combinational EX-stage datapath producing ALUOutput for memory, immediate
// and register-register opcodes.
module vsap_alu import vsap_pkg::*; #(
   parameter int DW = 8
) (
   input  logic [2:0]    op_i,
   input  logic [2:0]    fun_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   input  logic [DW-1:0] imm_i,
   output logic [DW-1:0] res_o
);
   logic [DW-1:0] fn_r;
   always_comb begin
      case (fun_i)
         F_ADD:   fn_r = a_i + b_i;
         F_SUB:   fn_r = a_i - b_i;
         F_AND:   fn_r = a_i & b_i;
         F_OR:    fn_r = a_i | b_i;
         F_XOR:   fn_r = a_i ^ b_i;
         F_NOT:   fn_r = ~a_i;
         F_SRL:   fn_r = {1'b0, a_i[DW-1:1]};
         default: fn_r = {a_i[DW-1], a_i[DW-1:1]};
      endcase
      res_o = op_i == OP_SUBI ? a_i - imm_i : op_i == OP_ALU ? fn_r : a_i + imm_i;
   end
endmodule

// File: rtl/vsap_core.sv
// vsap_core: non-pipelined IF/ID/EX/MEM/WB processor with ready/ack memory handshakes.
// Define VSAP_TRAP_EN to make opcode 7 raise a sticky trap and halt in EX; otherwise it is a NOP.
module vsap_core import vsap_pkg::*; #(
   parameter  int DW      = 8,
   parameter  int PCW     = 6,
   parameter  int NREG    = 4,
   parameter  int PC_STEP = 2,
   localparam int RAW     = $clog2(NREG),
   localparam int IW      = 3*RAW+6,
   localparam int IMMW    = RAW+3
) (
   input  logic           clock,
   input  logic           reset_n,
   output logic [PCW-1:0] imem_addr,
   output logic           imem_req,
   input  logic           imem_ack,
   input  logic [IW-1:0]  instruction,
   output logic [DW-1:0]  dmem_addr,
   output logic           dmem_req,
   output logic           dmem_wr,
   input  logic           dmem_ack,
   input  logic [DW-1:0]  datain,
   output logic [DW-1:0]  dataout,
   output logic           retire,
   output logic           trap
);
   state_e         state_q, state_d;
   logic [PCW-1:0] pc_q, pc_d, npc_q, npc_d, br_tgt;
   logic [IW-1:0]  ir_q, ir_d;
   logic [DW-1:0]  a_q, a_d, b_q, b_d, alu_q, alu_d, lmd_q, lmd_d, imm, alu_res;
   logic [DW-1:0]  rf_q [NREG];
   logic [DW-1:0]  rf_d [NREG];
   logic           cond_q, cond_d, ill, is_mem, is_br, wen;
   logic [2:0]     op, fun;
   logic [RAW-1:0] s1, s2, d, wsel;

   assign op     = ir_q[IW-1 -: 3];
   assign s1     = ir_q[IW-4 -: RAW];
   assign s2     = ir_q[IW-4-RAW -: RAW];
   assign d      = ir_q[RAW+2:3];
   assign fun    = ir_q[2:0];
   assign imm    = DW'(sext(64'(ir_q[IMMW-1:0]), IMMW));
   assign br_tgt = npc_q + PCW'(sext(64'(ir_q[IMMW-1:0]), IMMW) << 1);
   assign is_mem = op == OP_LW || op == OP_SW;
   assign is_br  = op == OP_BEQZ || op == OP_BNEZ;
   assign wen    = op == OP_ALU || op == OP_ADDI || op == OP_SUBI || op == OP_LW;
   assign wsel   = op == OP_ALU ? d : s2;

   vsap_alu #(.DW(DW)) u_alu (
      .op_i (op),
      .fun_i(fun),
      .a_i  (a_q),
      .b_i  (b_q),
      .imm_i(imm),
      .res_o(alu_res)
   );

`ifdef VSAP_TRAP_EN
   logic trap_q;
   assign ill  = op == OP_ILL;
   assign trap = trap_q;
   always_ff @(posedge clock) trap_q <= reset_n && (trap_q || (state_q == S_EX && ill));
`else
   assign ill  = 1'b0;
   assign trap = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      npc_d   = npc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      alu_d   = alu_q;
      lmd_d   = lmd_q;
      cond_d  = cond_q;
      rf_d    = rf_q;
      case (state_q)
         S_IF: if (imem_ack) begin
            ir_d    = instruction;
            npc_d   = pc_q + PCW'(PC_STEP);
            state_d = S_ID;
         end
         S_ID: begin
            a_d     = rf_q[s1];
            b_d     = rf_q[s2];
            state_d = S_EX;
         end
         S_EX: begin
            alu_d   = is_br ? DW'(br_tgt) : alu_res;
            cond_d  = is_br ? (op == OP_BNEZ) ^ (a_q == '0) : cond_q;
            state_d = ill ? S_EX : S_MEM;
         end
         S_MEM: if (!is_mem || dmem_ack) begin
            lmd_d   = op == OP_LW ? datain : lmd_q;
            pc_d    = is_br && cond_q ? PCW'(alu_q) : npc_q;
            state_d = S_WB;
         end
         S_WB: begin
            if (wen && wsel != '0) rf_d[wsel] = op == OP_LW ? lmd_q : alu_q;
            state_d = S_IF;
         end
         default: state_d = S_IF;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= S_IF;
         pc_q    <= '0;
         npc_q   <= '0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         alu_q   <= '0;
         lmd_q   <= '0;
         cond_q  <= 1'b0;
         rf_q    <= '{default: '0};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         npc_q   <= npc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         alu_q   <= alu_d;
         lmd_q   <= lmd_d;
         cond_q  <= cond_d;
         rf_q    <= rf_d;
      end
   end

   assign imem_addr = pc_q;
   assign imem_req  = state_q == S_IF;
   assign dmem_addr = alu_q;
   assign dmem_req  = state_q == S_MEM && is_mem;
   assign dmem_wr   = dmem_req && op == OP_SW;
   assign dataout   = b_q;
   assign retire    = state_q == S_WB;

   always_ff @(posedge clock) begin
      if (reset_n) begin
         assert (state_q inside {S_IF, S_ID, S_EX, S_MEM, S_WB});
         assert (!dmem_req || state_q == S_MEM);
         assert (!retire || state_q == S_WB);
         assert (rf_q[0] == '0);
      end
   end
endmodule

// File: tb/tb_vsap_core.sv
// tb_vsap_core: directed program runs for vsap_core with a retire/store scoreboard.
module tb_vsap_core;
   logic       clock = 1'b0, reset_n = 1'b0, imem_ack = 1'b1, dmem_ack = 1'b1;
   logic       imem_req, dmem_req, dmem_wr, retire, trap;
   logic [5:0] imem_addr;
   logic [11:0] instruction;
   logic [7:0] dmem_addr, datain, dataout;
   logic [11:0] imem [32];
   int errors = 0, checks = 0, cyc = 0, last_ret = -1, reqc = 0, wrc = 0, iwait = 0, dwait = 0;
   bit hold_st = 1'b0;

   typedef struct {int pc; int gap; int reqc; int wrc; bit st; int addr; int data;} exp_t;
   exp_t rq[$];

   vsap_core dut (
      .clock(clock), .reset_n(reset_n),
      .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .instruction(instruction),
      .dmem_addr(dmem_addr), .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_ack(dmem_ack),
      .datain(datain), .dataout(dataout), .retire(retire), .trap(trap)
   );

   always #5 clock = ~clock;
   assign instruction = imem[imem_addr[5:1]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic logic [11:0] fi(input logic [2:0] op, input logic [1:0] s1, input logic [1:0] d,
                                       input logic [4:0] imm);
      return {op, s1, d, imm};
   endfunction

   function automatic logic [11:0] fr(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] d,
                                       input logic [2:0] fun);
      return {3'd3, s1, s2, d, fun};
   endfunction

   task automatic push(input int pc, input int gap, input int rc, input int wc,
                       input bit st = 1'b0, input int addr = 0, input int data = 0);
      rq.push_back('{pc, gap, rc, wc, st, addr, data});
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && rq.size() > 0; i++) begin
         @(negedge clock);
         #1;
      end
      chk("scoreboard drained", rq.size(), 0);
   endtask

   always @(posedge clock) begin
      if (!reset_n) begin
         cyc = 0;
         last_ret = -1;
         reqc = 0;
         wrc = 0;
      end else cyc++;
   end

   // Ack responder: wait counts apply only while the matching request is up.
   always @(negedge clock) begin
      if (reset_n) begin
         imem_ack = !(imem_req && iwait > 0);
         if (imem_req && iwait > 0) iwait--;
         dmem_ack = !(dmem_req && (dmem_wr ? hold_st : dwait > 0));
         if (dmem_req && !dmem_wr && dwait > 0) dwait--;
      end
   end

   always @(negedge clock) begin
      if (reset_n) begin
         exp_t e;
         reqc += int'(dmem_req);
         wrc += int'(dmem_wr);
         if (retire) begin
            chk("retire expected", rq.size() > 0, 1);
            if (rq.size() > 0) begin
               e = rq.pop_front();
               chk($sformatf("pc after retire (want %0d)", e.pc), imem_addr, e.pc);
               chk($sformatf("cycles to retire pc %0d", e.pc), cyc - last_ret, e.gap);
               chk($sformatf("dmem_req cycles pc %0d", e.pc), reqc, e.reqc);
               chk($sformatf("dmem_wr cycles pc %0d", e.pc), wrc, e.wrc);
               if (e.st) begin
                  chk($sformatf("store addr pc %0d", e.pc), dmem_addr, e.addr);
                  chk($sformatf("store data pc %0d", e.pc), dataout, e.data);
               end
            end
            last_ret = cyc;
            reqc = 0;
            wrc = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      datain = 8'h5A;
      dwait = 3;
      foreach (imem[i]) imem[i] = 12'hE00;
      imem[0]  = fi(3'd4, 2'd0, 2'd1, 5'h1D);
      imem[1]  = fi(3'd1, 2'd0, 2'd1, 5'd0);
      imem[2]  = fi(3'd4, 2'd0, 2'd1, 5'd5);
      imem[3]  = fi(3'd4, 2'd0, 2'd2, 5'd7);
      imem[4]  = fr(2'd1, 2'd2, 2'd3, 3'd1);
      imem[5]  = fi(3'd1, 2'd0, 2'd3, 5'd1);
      imem[6]  = fr(2'd3, 2'd0, 2'd3, 3'd7);
      imem[7]  = fi(3'd1, 2'd0, 2'd3, 5'd2);
      imem[8]  = fr(2'd3, 2'd0, 2'd3, 3'd6);
      imem[9]  = fi(3'd1, 2'd0, 2'd3, 5'd3);
      imem[10] = fi(3'd0, 2'd0, 2'd2, 5'd4);
      imem[11] = fi(3'd1, 2'd0, 2'd2, 5'd5);
      imem[12] = fi(3'd5, 2'd1, 2'd1, 5'h1E);
      imem[13] = fr(2'd1, 2'd2, 2'd3, 3'd4);
      imem[14] = fi(3'd1, 2'd0, 2'd3, 5'd6);
      imem[15] = fi(3'd4, 2'd1, 2'd0, 5'd1);
      imem[16] = fi(3'd1, 2'd1, 2'd0, 5'd7);
      imem[18] = fi(3'd2, 2'd0, 2'd0, 5'd4);
      imem[23] = fi(3'd6, 2'd0, 2'd0, 5'd4);
      imem[24] = fi(3'd6, 2'd1, 2'd0, 5'd1);
      imem[26] = fi(3'd2, 2'd1, 2'd0, 5'd3);
      imem[27] = fi(3'd2, 2'd0, 2'd0, 5'd3);
      imem[31] = fi(3'd2, 2'd0, 2'd0, 5'd1);
      repeat (3) @(posedge clock);
      #1;
      chk("reset imem_req", imem_req, 1);
      chk("reset imem_addr", imem_addr, 0);
      chk("reset dmem_req", dmem_req, 0);
      chk("reset dmem_wr", dmem_wr, 0);
      chk("reset retire", retire, 0);
      chk("reset trap", trap, 0);
      push(2, 5, 0, 0);
      push(4, 5, 1, 1, 1, 0, 'hFD);
      push(6, 5, 0, 0);
      push(8, 5, 0, 0);
      push(10, 5, 0, 0);
      push(12, 5, 1, 1, 1, 1, 'hFE);
      push(14, 5, 0, 0);
      push(16, 5, 1, 1, 1, 2, 'hFF);
      push(18, 5, 0, 0);
      push(20, 5, 1, 1, 1, 3, 'h7F);
      push(22, 8, 4, 0);
      push(24, 5, 1, 1, 1, 5, 'h5A);
      push(26, 5, 0, 0);
      push(28, 5, 0, 0);
      push(30, 5, 1, 1, 1, 6, 'h5D);
      push(32, 5, 0, 0);
      push(34, 5, 1, 1, 1, 'h0E, 0);
`ifndef VSAP_TRAP_EN
      push(36, 5, 0, 0);
      push(46, 5, 0, 0);
      push(48, 5, 0, 0);
      push(52, 5, 0, 0);
      push(54, 5, 0, 0);
      push(62, 5, 0, 0);
      push(2, 5, 0, 0);
`endif
      reset_n = 1'b1;
      drain(300);
`ifdef VSAP_TRAP_EN
      repeat (20) @(negedge clock);
      #1;
      chk("trap set by opcode 7", trap, 1);
      chk("pc frozen on trap", imem_addr, 34);
      chk("no fetch while trapped", imem_req, 0);
`else
      chk("trap tied low", trap, 0);
`endif
      reset_n = 1'b0;
      hold_st = 1'b1;
      imem[0] = fi(3'd4, 2'd0, 2'd1, 5'd9);
      imem[1] = fi(3'd1, 2'd0, 2'd1, 5'd0);
      @(posedge clock);
      #1;
      chk("trap cleared by reset", trap, 0);
      reset_n = 1'b1;
      push(2, 5, 0, 0);
      drain(50);
      for (int i = 0; i < 20 && !(dmem_req && dmem_wr); i++) begin
         @(negedge clock);
         #1;
      end
      chk("store waiting in MEM", dmem_req && dmem_wr, 1);
      repeat (2) @(negedge clock);
      #1;
      chk("store still waiting", dmem_req, 1);
      reset_n = 1'b0;
      @(negedge clock);
      #1;
      chk("mid-wait reset imem_req", imem_req, 1);
      chk("mid-wait reset dmem_req", dmem_req, 0);
      chk("mid-wait reset dmem_wr", dmem_wr, 0);
      chk("mid-wait reset imem_addr", imem_addr, 0);
      chk("mid-wait reset retire", retire, 0);
      hold_st = 1'b0;
      iwait = 2;
      imem[0] = fi(3'd1, 2'd0, 2'd1, 5'd0);
      imem[1] = fi(3'd1, 2'd0, 2'd2, 5'd1);
      imem[2] = fi(3'd1, 2'd0, 2'd3, 5'd2);
      push(2, 7, 1, 1, 1, 0, 0);
      push(4, 5, 1, 1, 1, 1, 0);
      push(6, 5, 1, 1, 1, 2, 0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      drain(60);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
